// File: rtl/scu_trap_ctrl.sv
// Trap/mret sequencer that owns the machine CSR file write port and issues the pipeline flush.
// Define SCU_MTVAL_EN to add the T_TVAL state so that mtval is written after mcause.
module scu_trap_ctrl #(
  parameter int XLEN     = 32,
  parameter bit IRQ_SYNC = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_scu_wen,
  input  logic [11:0]     i_scu_waddr,
  input  logic [XLEN-1:0] i_scu_wdata,
  output logic            o_scu_stall,
  input  logic            i_exc_vld,
  input  logic [3:0]      i_exc_cause,
  input  logic [XLEN-1:0] i_exc_pc,
  input  logic [XLEN-1:0] i_exc_tval,
  input  logic            i_mret,
  input  logic [XLEN-1:0] i_int_pc,
  input  logic            i_irq_ext,
  input  logic            i_irq_sw,
  input  logic            i_irq_tmr,
  input  logic [XLEN-1:0] i_mstatus,
  input  logic [XLEN-1:0] i_mie,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mepc,
  output logic            o_csrf_wen,
  output logic [11:0]     o_csrf_waddr,
  output logic [XLEN-1:0] o_csrf_wdata,
  output logic            o_flush,
  output logic [XLEN-1:0] o_flush_pc,
  output logic            o_busy
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
`ifdef SCU_MTVAL_EN
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_T_EPC,
    S_T_CAUSE,
`ifdef SCU_MTVAL_EN
    S_T_TVAL,
`endif
    S_T_STAT,
    S_R_STAT,
    S_FLUSH
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic            irq_q, irq_d;
`ifdef SCU_MTVAL_EN
  logic [XLEN-1:0] tval_q, tval_d;
`else
  logic            unused_tval;
  assign unused_tval = ^i_exc_tval;
`endif

  logic            wen_d, flush_d, busy_d;
  logic [11:0]     waddr_d;
  logic [XLEN-1:0] wdata_d, flush_pc_d;

  // Interrupt levels as {ext, sw, tmr}, optionally brought into the core clock domain.
  logic [2:0] irq_raw, irq_lvl;
  assign irq_raw = {i_irq_ext, i_irq_sw, i_irq_tmr};

  generate
    if (IRQ_SYNC) begin : g_sync
      logic [2:0] sync1_q, sync2_q;
      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
          sync1_q <= '0;
          sync2_q <= '0;
        end else begin
          sync1_q <= irq_raw;
          sync2_q <= sync1_q;
        end
      end
      assign irq_lvl = sync2_q;
    end else begin : g_nosync
      assign irq_lvl = irq_raw;
    end
  endgenerate

  logic [XLEN-1:0] mip, irq_en;
  logic            irq_pend;
  logic [3:0]      irq_code;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mip      = '0;
    mip[11]  = irq_lvl[2];
    mip[3]   = irq_lvl[1];
    mip[7]   = irq_lvl[0];
    irq_en   = mip & i_mie;
    irq_pend = i_mstatus[3] & (|irq_en);
    irq_code = 4'd7;
    if (irq_en[3])  irq_code = 4'd3;
    if (irq_en[11]) irq_code = 4'd11;
  end

  logic is_idle, take_exc, take_irq, take_mret, take_trap, scu_acc;

  always_comb begin
    is_idle   = (state_q == S_IDLE);
    take_exc  = is_idle & i_exc_vld;
    take_irq  = is_idle & ~i_exc_vld & irq_pend;
    take_mret = is_idle & ~i_exc_vld & ~irq_pend & i_mret;
    take_trap = take_exc | take_irq;
    scu_acc   = is_idle & i_scu_wen & ~(i_exc_vld | irq_pend | i_mret);
  end

  assign o_scu_stall = i_scu_wen & ~scu_acc;

  always_comb begin
    pc_d    = pc_q;
    cause_d = cause_q;
    irq_d   = irq_q;
`ifdef SCU_MTVAL_EN
    tval_d  = tval_q;
`endif
    if (take_trap) begin
      pc_d    = take_exc ? i_exc_pc : i_int_pc;
      cause_d = take_exc ? XLEN'(i_exc_cause) : {1'b1, {(XLEN-5){1'b0}}, irq_code};
      irq_d   = take_irq;
`ifdef SCU_MTVAL_EN
      tval_d  = take_exc ? i_exc_tval : '0;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (take_trap)      state_d = S_T_EPC;
        else if (take_mret) state_d = S_R_STAT;
      end
      S_T_EPC:   state_d = S_T_CAUSE;
`ifdef SCU_MTVAL_EN
      S_T_CAUSE: state_d = S_T_TVAL;
      S_T_TVAL:  state_d = S_T_STAT;
`else
      S_T_CAUSE: state_d = S_T_STAT;
`endif
      S_T_STAT:  state_d = S_FLUSH;
      S_R_STAT:  state_d = S_FLUSH;
      S_FLUSH:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  logic [XLEN-1:0] ms_trap, ms_mret, vec_base, trap_pc;

  always_comb begin
    ms_trap        = i_mstatus;
    ms_trap[7]     = i_mstatus[3];
    ms_trap[3]     = 1'b0;
    ms_trap[12:11] = 2'b11;
    ms_mret        = i_mstatus;
    ms_mret[3]     = i_mstatus[7];
    ms_mret[7]     = 1'b1;
    ms_mret[12:11] = 2'b11;
    vec_base       = {i_mtvec[XLEN-1:2], 2'b00};
    trap_pc        = vec_base;
    if (i_mtvec[1:0] == 2'b01 && irq_q)
      trap_pc = vec_base + XLEN'({cause_q[3:0], 2'b00});
  end

  // Outputs are decoded from the next state so every port except the stall comes from a flop.
  always_comb begin
    wen_d      = 1'b0;
    waddr_d    = '0;
    wdata_d    = '0;
    flush_d    = 1'b0;
    flush_pc_d = '0;
    case (state_d)
      S_IDLE: begin
        if (scu_acc) begin
          wen_d   = 1'b1;
          waddr_d = i_scu_waddr;
          wdata_d = i_scu_wdata;
        end
      end
      S_T_EPC: begin
        wen_d   = 1'b1;
        waddr_d = CSR_MEPC;
        wdata_d = pc_d;
      end
      S_T_CAUSE: begin
        wen_d   = 1'b1;
        waddr_d = CSR_MCAUSE;
        wdata_d = cause_q;
      end
`ifdef SCU_MTVAL_EN
      S_T_TVAL: begin
        wen_d   = 1'b1;
        waddr_d = CSR_MTVAL;
        wdata_d = tval_q;
      end
`endif
      S_T_STAT: begin
        wen_d   = 1'b1;
        waddr_d = CSR_MSTATUS;
        wdata_d = ms_trap;
      end
      S_R_STAT: begin
        wen_d   = 1'b1;
        waddr_d = CSR_MSTATUS;
        wdata_d = ms_mret;
      end
      S_FLUSH: begin
        flush_d    = 1'b1;
        flush_pc_d = (state_q == S_R_STAT) ? i_mepc : trap_pc;
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      cause_q      <= '0;
      irq_q        <= 1'b0;
`ifdef SCU_MTVAL_EN
      tval_q       <= '0;
`endif
      o_csrf_wen   <= 1'b0;
      o_csrf_waddr <= '0;
      o_csrf_wdata <= '0;
      o_flush      <= 1'b0;
      o_flush_pc   <= '0;
      o_busy       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cause_q      <= cause_d;
      irq_q        <= irq_d;
`ifdef SCU_MTVAL_EN
      tval_q       <= tval_d;
`endif
      o_csrf_wen   <= wen_d;
      o_csrf_waddr <= waddr_d;
      o_csrf_wdata <= wdata_d;
      o_flush      <= flush_d;
      o_flush_pc   <= flush_pc_d;
      o_busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_scu_trap_ctrl.sv
// Scoreboard bench for scu_trap_ctrl: the driver queues the expected CSR writes and flushes,
// and a negedge monitor pops and compares them whenever the DUT writes or flushes.
module tb_scu_trap_ctrl;

`ifdef SCU_MTVAL_EN
  localparam int TRAP_STATES = 4;
`else
  localparam int TRAP_STATES = 3;
`endif

  logic        clk, rst_n;
  logic        i_scu_wen;
  logic [11:0] i_scu_waddr;
  logic [31:0] i_scu_wdata;
  logic        o_scu_stall;
  logic        i_exc_vld;
  logic [3:0]  i_exc_cause;
  logic [31:0] i_exc_pc, i_exc_tval;
  logic        i_mret;
  logic [31:0] i_int_pc;
  logic        i_irq_ext, i_irq_sw, i_irq_tmr;
  logic [31:0] i_mstatus, i_mie, i_mtvec, i_mepc;
  logic        o_csrf_wen;
  logic [11:0] o_csrf_waddr;
  logic [31:0] o_csrf_wdata;
  logic        o_flush;
  logic [31:0] o_flush_pc;
  logic        o_busy;

  scu_trap_ctrl #(.XLEN(32), .IRQ_SYNC(1'b1)) dut (
    .i_clk(clk), .i_rstn(rst_n),
    .i_scu_wen(i_scu_wen), .i_scu_waddr(i_scu_waddr), .i_scu_wdata(i_scu_wdata),
    .o_scu_stall(o_scu_stall),
    .i_exc_vld(i_exc_vld), .i_exc_cause(i_exc_cause), .i_exc_pc(i_exc_pc),
    .i_exc_tval(i_exc_tval), .i_mret(i_mret), .i_int_pc(i_int_pc),
    .i_irq_ext(i_irq_ext), .i_irq_sw(i_irq_sw), .i_irq_tmr(i_irq_tmr),
    .i_mstatus(i_mstatus), .i_mie(i_mie), .i_mtvec(i_mtvec), .i_mepc(i_mepc),
    .o_csrf_wen(o_csrf_wen), .o_csrf_waddr(o_csrf_waddr), .o_csrf_wdata(o_csrf_wdata),
    .o_flush(o_flush), .o_flush_pc(o_flush_pc), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_flush;
    logic [11:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_exp(input logic f, input logic [11:0] a, input logic [31:0] d);
    exp_t e;
    e.is_flush = f;
    e.addr     = a;
    e.data     = d;
    sb_q.push_back(e);
  endfunction

  // Reference rules, stated as field arithmetic on the architectural CSR values.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r = m & ~32'h0000_1888;
    if (m[3]) r = r + 32'h80;
    return r + 32'h1800;
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r = m & ~32'h0000_1888;
    if (m[7]) r = r + 32'h8;
    return r + 32'h1880;
  endfunction

  function automatic logic [31:0] redirect(input logic [31:0] mtvec, input bit irq, input int code);
    int unsigned mode;
    logic [31:0] base;
    mode = mtvec % 4;
    base = mtvec - mode;
    if (mode == 1 && irq) return base + 32'(4 * code);
    return base;
  endfunction

  function automatic bit irq_pending(input logic [2:0] lines, input logic [31:0] mst, input logic [31:0] mie);
    return mst[3] && ((lines[2] && mie[11]) || (lines[1] && mie[3]) || (lines[0] && mie[7]));
  endfunction

  function automatic int irq_cause(input logic [2:0] lines, input logic [31:0] mie);
    if (lines[2] && mie[11]) return 11;
    if (lines[1] && mie[3])  return 3;
    return 7;
  endfunction

  task automatic push_trap(input bit irq, input int code, input logic [31:0] pc, input logic [31:0] tval);
    push_exp(1'b0, 12'h341, pc);
    push_exp(1'b0, 12'h342, irq ? 32'h8000_0000 + 32'(code) : 32'(code));
`ifdef SCU_MTVAL_EN
    push_exp(1'b0, 12'h343, irq ? 32'h0 : tval);
`else
    if (tval === 32'hx) push_exp(1'b0, 12'h343, 32'h0);
`endif
    push_exp(1'b0, 12'h300, trap_mstatus(i_mstatus));
    push_exp(1'b1, 12'h000, redirect(i_mtvec, irq, code));
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (o_csrf_wen) begin
        if (sb_q.size() == 0) check("unexpected_csr_wen", 32'(o_csrf_wen), 32'h0);
        else begin
          e = sb_q.pop_front();
          check("csr_write_expected", 32'(o_csrf_wen), 32'(!e.is_flush));
          check("csr_waddr", 32'(o_csrf_waddr), 32'(e.addr));
          check("csr_wdata", o_csrf_wdata, e.data);
        end
      end
      if (o_flush) begin
        if (sb_q.size() == 0) check("unexpected_flush", 32'(o_flush), 32'h0);
        else begin
          e = sb_q.pop_front();
          check("flush_expected", 32'(o_flush), 32'(e.is_flush));
          check("flush_pc", o_flush_pc, e.data);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_csrf_wen"}, 32'(o_csrf_wen), 32'h0);
    check({tag, "_csrf_waddr"}, 32'(o_csrf_waddr), 32'h0);
    check({tag, "_csrf_wdata"}, o_csrf_wdata, 32'h0);
    check({tag, "_flush"}, 32'(o_flush), 32'h0);
    check({tag, "_flush_pc"}, o_flush_pc, 32'h0);
    check({tag, "_busy"}, 32'(o_busy), 32'h0);
    check({tag, "_scu_stall"}, 32'(o_scu_stall), 32'h0);
  endtask

  // Called at a negedge with an idle DUT; CSR values and payloads are already on the inputs.
  task automatic run_txn(input bit do_exc, input bit do_irq, input bit do_mret, input bit do_scu,
                         input bit spurious, input logic [2:0] lines, input int min_cyc);
    int  stalls;
    int  exp_stalls;
    bit  scu_pend;
    bit  done;
    if (do_exc) push_trap(1'b0, int'(i_exc_cause), i_exc_pc, i_exc_tval);
    else if (do_mret) begin
      push_exp(1'b0, 12'h300, mret_mstatus(i_mstatus));
      push_exp(1'b1, 12'h000, i_mepc);
    end
    if (do_irq && irq_pending(lines, i_mstatus, i_mie))
      push_trap(1'b1, irq_cause(lines, i_mie), i_int_pc, 32'h0);
    exp_stalls = do_exc ? TRAP_STATES + 2 : (do_mret ? 3 : 0);
    i_exc_vld = do_exc;
    i_mret    = do_mret;
    {i_irq_ext, i_irq_sw, i_irq_tmr} = do_irq ? lines : 3'b000;
    i_scu_wen = do_scu;
    scu_pend  = do_scu;
    stalls    = 0;
    done      = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        if (cyc == 1) begin i_exc_vld = 1'b0; i_mret = 1'b0; end
        if (spurious && cyc == 2) begin i_exc_vld = 1'b1; i_mret = 1'b1; end
        if (spurious && cyc == 3) begin i_exc_vld = 1'b0; i_mret = 1'b0; end
        if (!scu_pend) i_scu_wen = 1'b0;
      end
      #2;
      if (scu_pend) begin
        if (o_scu_stall) stalls++;
        else begin
          scu_pend = 1'b0;
          push_exp(1'b0, i_scu_waddr, i_scu_wdata);
        end
      end
      if (o_csrf_wen && o_csrf_waddr == 12'h342 && o_csrf_wdata[31])
        {i_irq_ext, i_irq_sw, i_irq_tmr} = 3'b000;
      done = (cyc >= min_cyc) && (sb_q.size() == 0) && !o_busy && !scu_pend;
    end
    check("txn_drained", 32'(done), 32'h1);
    if (do_scu) check("scu_stall_cycles", 32'(stalls), 32'(exp_stalls));
    if (!done) sb_q.delete();
    i_exc_vld = 1'b0;
    i_mret    = 1'b0;
    i_scu_wen = 1'b0;
    {i_irq_ext, i_irq_sw, i_irq_tmr} = 3'b000;
    repeat (4) @(negedge clk);
  endtask

  task automatic randomize_payload();
    i_mstatus   = $urandom;
    i_mie       = $urandom;
    i_mtvec     = $urandom & ~32'h2;
    i_mepc      = $urandom;
    i_exc_cause = 4'($urandom);
    i_exc_pc    = $urandom;
    i_exc_tval  = $urandom;
    i_int_pc    = $urandom;
    i_scu_waddr = 12'($urandom);
    i_scu_wdata = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] lines;
    int         kind;
    bit         spur;
    rst_n = 1'b0;
    i_exc_vld = 1'b0; i_mret = 1'b0;
    {i_irq_ext, i_irq_sw, i_irq_tmr} = 3'b000;
    randomize_payload();
    i_scu_wen   = 1'b1;
    i_scu_waddr = 12'h305;
    i_scu_wdata = 32'h0000_ABCD;
    repeat (3) @(negedge clk);
    #2 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 0);

    // Synchronous exception with direct-mode mtvec.
    i_mstatus = 32'h8; i_mtvec = 32'h100; i_exc_cause = 4'd2; i_exc_pc = 32'h80; i_exc_tval = 32'h1234;
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 0);

    // Timer and external pending, vectored mode: external wins.
    i_mie = 32'h888; i_mtvec = 32'h101; i_int_pc = 32'h400;
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b101, 0);

    i_mstatus = 32'h1880; i_mepc = 32'h200;
    run_txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 0);

    // SCU write colliding with an exception is held off until the trap completes.
    i_mstatus = 32'h8; i_mtvec = 32'h100; i_scu_waddr = 12'h305; i_scu_wdata = 32'h40;
    run_txn(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 0);

    // Vectored target wraps past the top of the address space.
    i_mstatus = 32'h8; i_mie = 32'h800; i_mtvec = 32'hFFFF_FFF1;
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 0);

    // Reset during T_CAUSE: mepc and mcause stand, nothing afterwards.
    i_mstatus = 32'h8; i_exc_cause = 4'd5; i_exc_pc = 32'h3000;
    push_exp(1'b0, 12'h341, 32'h3000);
    push_exp(1'b0, 12'h342, 32'h5);
    i_exc_vld = 1'b1;
    @(negedge clk);
    i_exc_vld = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    #2 check("midrst_queue_empty", 32'(sb_q.size()), 32'h0);
    @(negedge clk);

    // Interrupts blocked by mstatus.MIE and by mie are never taken.
    i_mstatus = 32'h0; i_mie = 32'h888;
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 10);
    i_mstatus = 32'h8; i_mie = 32'h0;
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 10);

    for (int t = 0; t < 160; t++) begin
      randomize_payload();
      kind  = $urandom_range(0, 7);
      spur  = 1'($urandom_range(0, 1));
      lines = 3'($urandom_range(1, 7));
      if (kind == 5 || kind == 6) begin
        i_mstatus[3] = 1'b1;
        if (!irq_pending(lines, i_mstatus, i_mie)) begin
          if (lines[2])      i_mie[11] = 1'b1;
          else if (lines[1]) i_mie[3]  = 1'b1;
          else               i_mie[7]  = 1'b1;
        end
      end
      if (kind == 7) begin
        if ($urandom_range(0, 1) == 0) i_mstatus[3] = 1'b0;
        else                           i_mie = i_mie & ~32'h888;
      end
      case (kind)
        0: run_txn(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 0);
        1: run_txn(1'b1, 1'b0, 1'b0, 1'b0, spur, 3'b000, 0);
        2: run_txn(1'b1, 1'b0, 1'b0, 1'b1, spur, 3'b000, 0);
        3: run_txn(1'b0, 1'b0, 1'b1, 1'b0, spur, 3'b000, 0);
        4: run_txn(1'b0, 1'b0, 1'b1, 1'b1, spur, 3'b000, 0);
        5: run_txn(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, lines, 0);
        6: run_txn(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, lines, 0);
        default: run_txn(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, lines, 10);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
